memory_verify: RTL and testbench
================================

Name: memory_verify

Overview:
- Read-back checker that runs after the memory blanking pass.
- Sweeps the same 18-bit external SRAM address range, reads every word and compares it against the blanking fill pattern.
- Reports done, pass/fail, mismatch count and the first failing address/data.
- Shares the memory bus through the same pause/enable/done arbitration as the blanking writer, so the top-level sequencer can run blank, then verify.

Parameters:
- ADDR_WIDTH, 18, SRAM address width.
- DATA_WIDTH, 32, SRAM data width.
- PATTERN, 32'h77553311, expected content of every checked word.
- LAST_ADDR, 262141, final address checked; range is 0..LAST_ADDR inclusive, matching the blanking pass.
- READ_LATENCY, 2, cycles from an issued address to valid data_read; legal range 1..4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- enable  in  1  run request; low = idle and clear.
- pause  in  1  memory arbiter stall; high = no read may be issued this cycle.
- data_read  in  DATA_WIDTH  SRAM read data.
- address  out  ADDR_WIDTH  SRAM read address.
- wren  out  1  write enable; always 0 (bus-mux compatibility).
- done  out  1  sweep complete, held while enable is high.
- pass  out  1  valid when done: 1 = zero mismatches.
- error_count  out  ADDR_WIDTH  mismatch count, saturating at all-ones.
- first_error_address  out  ADDR_WIDTH  address of first mismatch.
- first_error_data  out  DATA_WIDTH  data_read at first mismatch.

Behaviour:
- Reset/clear values:
  - reset high (async) drives every output to 0 and the state to IDLE.
  - enable low (synchronous) does the same.
- State machine: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on the first clk with enable=1.
  - ISSUE, pause=0: drive address=issue counter; push a valid tag carrying that address into a READ_LATENCY-deep shift pipeline; increment the counter.
  - ISSUE, pause=1: push an invalid tag; address holds its previous value; counter holds.
  - ISSUE -> DRAIN in the cycle that issues LAST_ADDR.
  - DRAIN: push invalid tags; when the pipeline holds no valid tags -> DONE.
  - DONE: done=1 and pass=(error_count==0) in the same cycle; stay until enable falls.
- Read pipeline:
  - The pipeline shifts every cycle regardless of pause.
  - data_read is sampled in the cycle a valid tag exits, i.e. READ_LATENCY cycles after issue.
- Compare: on a valid tag exit, data_read != PATTERN causes:
  - error_count increments, saturating at all-ones.
  - If it is the first mismatch, first_error_address/first_error_data are captured and then frozen.
- Output stability: done and pass stay 0 until DONE; the other outputs update live during the run.
- Timing with no pause, enable sampled high at edge 0:
  - address k is driven after edge k+1.
  - done rises after edge LAST_ADDR+READ_LATENCY+2.
- enable drop mid-run: all state is cleared on the next edge; in-flight reads are discarded. Re-raising enable restarts from address 0 with counters at 0.
- reset mid-run: immediate clear; no partial result remains visible.
- wren is constant 0 in all states.

Test Plan:
- LAST_ADDR=15, READ_LATENCY=2, memory model returns PATTERN, no pause -> addresses 0..15 in consecutive cycles; done rises after edge 19; pass=1; error_count=0.
- LAST_ADDR=15, model corrupts addr 5 (0xDEADBEEF) and addr 9 -> done=1, pass=0, error_count=2, first_error_address=5, first_error_data=0xDEADBEEF.
- LAST_ADDR=15, pause high on cycles 3-6 and 10 -> no address issued during pause; all 16 addresses still checked exactly once; done delayed 5 cycles; pass=1.
- Run started, enable dropped at address 8, then re-raised -> outputs 0 one edge after the drop; the second run checks 0..15 fully; error_count counts only second-run mismatches.
- Async reset pulsed between edges mid-DRAIN -> outputs 0 immediately without waiting for a clk edge; state IDLE; the next enable gives a clean full run.
- Default parameters with all-PATTERN memory -> done after 262141+2+2 edges; pass=1; wren=0 throughout.

Source files
------------

// File: rtl/memory_verify.sv
// Read-back checker: sweeps the SRAM range after blanking, compares each word against the
// fill pattern and reports done/pass, a saturating mismatch count and the first failure.
module memory_verify #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PATTERN = 32'h77553311,
  parameter int unsigned LAST_ADDR = 262141,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pause,
  input  logic [DATA_WIDTH-1:0] data_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wren,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] error_count,
  output logic [ADDR_WIDTH-1:0] first_error_address,
  output logic [DATA_WIDTH-1:0] first_error_data
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] CountMax = '1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] err_q;
  logic [ADDR_WIDTH-1:0] fea_q;
  logic [DATA_WIDTH-1:0] fed_q;
  // Tag pipeline: one slot per cycle of read latency, carrying the address that was issued.
  logic                  tag_v_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] tag_a_q [READ_LATENCY];

  logic issue;
  logic exit_v;
  logic mismatch;
  logic pending;

  assign issue    = (state_q == StIssue) && !pause;
  assign exit_v   = tag_v_q[READ_LATENCY-1];
  assign mismatch = exit_v && (data_read != PATTERN);

  // Any read still in flight keeps the FSM in DRAIN.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < int'(READ_LATENCY); i++) pending = pending | tag_v_q[i];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping enable returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StIssue;
      StIssue: if (issue && (cnt_q == LastAddr)) state_d = StDrain;
      StDrain: if (!pending) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  // Issue counter, read-tag pipeline and compare results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
      err_q  <= '0;
      fea_q  <= '0;
      fed_q  <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        tag_v_q[i] <= 1'b0;
        tag_a_q[i] <= '0;
      end
    end else if (!enable) begin
      cnt_q  <= '0;
      addr_q <= '0;
      err_q  <= '0;
      fea_q  <= '0;
      fed_q  <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        tag_v_q[i] <= 1'b0;
        tag_a_q[i] <= '0;
      end
    end else begin
      for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_a_q[i] <= tag_a_q[i-1];
      end
      tag_v_q[0] <= issue;
      tag_a_q[0] <= cnt_q;
      if (issue) begin
        addr_q <= cnt_q;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (mismatch) begin
        if (err_q != CountMax) err_q <= err_q + 1'b1;
        // A zero count means this is the first failure; later ones leave the capture alone.
        if (err_q == '0) begin
          fea_q <= tag_a_q[READ_LATENCY-1];
          fed_q <= data_read;
        end
      end
    end
  end

  assign address             = addr_q;
  assign wren                = 1'b0;
  assign done                = (state_q == StDone);
  assign pass                = (state_q == StDone) && (err_q == '0);
  assign error_count         = err_q;
  assign first_error_address = fea_q;
  assign first_error_data    = fed_q;

endmodule

// File: tb/tb_memory_verify.sv
// Bench for memory_verify: small SRAM model, expected run results queued by the stimulus and
// popped by a monitor whenever done rises.
module tb_memory_verify;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam logic [31:0] PAT = 32'h77553311;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          pause = 1'b0;
  logic [DW-1:0] data_read;
  logic [AW-1:0] address;
  logic          wren;
  logic          done;
  logic          pass;
  logic [AW-1:0] error_count;
  logic [AW-1:0] first_error_address;
  logic [DW-1:0] first_error_data;

  memory_verify #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .PATTERN     (PAT),
    .LAST_ADDR   (15),
    .READ_LATENCY(2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .pause              (pause),
    .data_read          (data_read),
    .address            (address),
    .wren               (wren),
    .done               (done),
    .pass               (pass),
    .error_count        (error_count),
    .first_error_address(first_error_address),
    .first_error_data   (first_error_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic        pass;
    int          err;
    int          fea;
    logic [31:0] fed;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   edge_idx = -1;
  int   start_idx = 0;
  int   wren_bad = 0;
  logic done_prev = 1'b0;
  logic corrupt = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [AW-1:0] a);
    if (corrupt && a == 18'd5) return 32'hDEADBEEF;
    if (corrupt && a == 18'd9) return 32'h12345678;
    return PAT;
  endfunction

  // Synchronous SRAM: data for the address on the bus appears one cycle later.
  always @(posedge clk) data_read <= model(address);

  // Monitor: counts edges, watches wren, and checks each completed run against the queue.
  always @(posedge clk) begin
    #1;
    edge_idx++;
    if (wren !== 1'b0) wren_bad++;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_latency", 64'(edge_idx - start_idx), 64'(mon_e.lat));
        chk("pass", pass, mon_e.pass);
        chk("error_count", error_count, 64'(mon_e.err));
        chk("first_error_address", first_error_address, 64'(mon_e.fea));
        chk("first_error_data", first_error_data, mon_e.fed);
      end
    end
    done_prev = done;
  end

  task automatic push(input int lat, input logic p, input int err, input int fea,
                      input logic [31:0] fed);
    exp_t e;
    e.lat = lat; e.pass = p; e.err = err; e.fea = fea; e.fed = fed;
    exp_q.push_back(e);
  endtask

  task automatic start_run();
    @(negedge clk);
    enable = 1'b1;
    start_idx = edge_idx + 1;
  endtask

  task automatic wait_done_and_clear();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_held", done, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("clear_done", done, 0);
    chk("clear_pass", pass, 0);
    chk("clear_address", address, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_error_count"}, error_count, 0);
    chk({tag, "_fea"}, first_error_address, 0);
    chk({tag, "_fed"}, first_error_data, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Clean sweep, no pause: address k visible after edge k+1, done after edge 19.
    push(19, 1'b1, 0, 0, 32'h0);
    start_run();
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("addr_seq", address, 64'(k));
    end
    wait_done_and_clear();

    // Two corrupted words: first failure at 5 is captured, count reaches 2.
    corrupt = 1'b1;
    push(19, 1'b0, 2, 5, 32'hDEADBEEF);
    start_run();
    wait_done_and_clear();
    corrupt = 1'b0;

    // Pause on edges 3-6 and 10: five stalls delay done by five cycles.
    push(24, 1'b1, 0, 0, 32'h0);
    start_run();
    for (int e = 1; e < 30; e++) begin
      @(negedge clk);
      if (e - 1 == 6)  chk("pause_hold_a", address, 1);
      if (e - 1 == 10) chk("pause_hold_b", address, 4);
      if (e - 1 == 11) chk("pause_resume", address, 5);
      pause = ((e >= 3) && (e <= 6)) || (e == 10);
    end
    pause = 1'b0;
    wait_done_and_clear();

    // Enable dropped at address 8, then a fresh run counts only its own mismatches.
    corrupt = 1'b1;
    start_run();
    n = 0;
    while (address != 18'd8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drop_reached_addr8", address, 8);
    chk("drop_err_before", error_count, 1);
    enable = 1'b0;
    @(negedge clk);
    chk_zero("drop");
    push(19, 1'b0, 2, 5, 32'hDEADBEEF);
    start_run();
    wait_done_and_clear();

    // Async reset between edges while draining clears outputs without a clock edge.
    start_run();
    repeat (18) @(negedge clk);
    chk("drain_not_done", done, 0);
    chk("drain_err", error_count, 2);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    chk_zero("async_reset");
    #1;
    reset = 1'b0;
    corrupt = 1'b0;
    push(19, 1'b1, 0, 0, 32'h0);
    start_run();
    wait_done_and_clear();

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    chk("wren_never_high", 64'(wren_bad), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
